seg_scan: RTL
=============

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter ND, default 8: number of displayed digits; window width is 4*ND bits.
REQ-002 Parameter SCAN_DIV, default 50000: clocks per digit slot, legal range >= 1.
REQ-003 Parameter STEP_DIV, default 25000000: clocks per step pulse while running, legal range >= 1.
REQ-004 Parameter BLANK, default 4'hA: nibble code shown as all segments off; any value > 15 disables blanking.
REQ-005 clk  input  1: rising-edge clock for all state.
REQ-006 rst_n  input  1: reset, synchronous to clk, active-low.
REQ-007 din  input  4*ND: hex-digit window from the rotating text register; nibble k drives digit k, and nibble ND-1 is leftmost.
REQ-008 run  input  1: enables generation of step pulses.
REQ-009 an  output  ND: digit enables, active-low, one-hot-low while scanning.
REQ-010 seg  output  7: segments a..g, active-low; seg[0]=a, seg[6]=g.
REQ-011 step  output  1: one-cycle pulse, used as the shift enable of the rotating text register.
REQ-012 frame  output  1: one-cycle pulse marking a new snapshot and digit 0 being driven.

Function
REQ-013 Prescaler counts 0..SCAN_DIV-1 and wraps; scan_tick = (count == SCAN_DIV-1); SCAN_DIV=1 gives a tick every cycle.
REQ-014 Digit index idx advances by 1 on each scan_tick edge and wraps from ND-1 to 0.
REQ-015 On a scan_tick edge where idx wraps to 0, snap SHALL load din and frame SHALL be 1 for that one cycle; frame SHALL be 0 otherwise.
REQ-016 Changes on din between snapshots SHALL have no effect on an or seg.
REQ-017 an and seg are registers updated on the same edge as idx, with no extra latency.
REQ-018 After a scan_tick edge, an SHALL have bit idx low and all other bits high.
REQ-019 After a scan_tick edge, seg SHALL decode the idx nibble of the post-edge snapshot; this is din at a wrap edge.
REQ-020 Decode, active-low hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-021 A nibble equal to BLANK SHALL decode to 7'h7F, overriding REQ-020.
REQ-022 Step counter counts 0..STEP_DIV-1 only while run=1.
REQ-023 step=1 for one cycle on the edge after the counter reaches STEP_DIV-1 with run=1; the counter then returns to 0.
REQ-024 run=0 SHALL freeze the step counter without clearing it, and no step pulse SHALL occur; this holds even if run falls in the terminal-count cycle.
REQ-025 Step and scan counters are independent; simultaneous step and frame pulses are legal.

Reset
REQ-026 While rst_n=0 at a clk edge, the following SHALL hold:
- prescaler = 0, step counter = 0, idx = ND-1;
- snap = all nibbles BLANK;
- an = all 1, seg = 7'h7F, step = 0, frame = 0.
REQ-027 Reset asserted mid-frame or mid-step-count SHALL abort the operation with no partial pulse.
REQ-028 After release, the first scan_tick wraps idx to 0, so the first frame pulse occurs SCAN_DIV clocks after the first unreset edge.

Verification (ND=4, SCAN_DIV=3, STEP_DIV=5, BLANK=4'hA)
REQ-029 rst_n=0 for 2 cycles -> an=4'hF, seg=7'h7F, step=0, frame=0.
REQ-030 Release with din=16'h1234, run=0 -> 3rd edge: frame=1, an=4'b1110, seg=7'h19; +3 edges: an=4'b1101, seg=7'h30; +3 edges: an=4'b1011, seg=7'h24.
REQ-031 din changed to 16'h5678 while idx=1 -> digits 2 and 3 still show 2 (seg=7'h24) and 1 (seg=7'h79); after the next frame pulse, an=4'b1110, seg=7'h00.
REQ-032 din=16'hAAA0 -> digits 1..3 seg=7'h7F, digit 0 seg=7'h40.
REQ-033 run=1 continuously -> step pulses every 5 cycles; run=0 for 2 cycles mid-count -> next pulse delayed by exactly 2 cycles.
REQ-034 rst_n=0 for one edge while idx=2 -> next cycle an=4'hF, seg=7'h7F; frame pulse 3 edges after release with din re-sampled.

Source files
------------

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner: snapshots a hex window once per frame, drives one
// digit per scan slot, and emits a free-running step pulse for the text rotator.
module seg_scan #(
  parameter int ND       = 8,
  parameter int SCAN_DIV = 50000,
  parameter int STEP_DIV = 25000000,
  parameter int BLANK    = 4'hA
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4*ND-1:0] din,
  input  logic            run,
  output logic [ND-1:0]   an,
  output logic [6:0]      seg,
  output logic            step,
  output logic            frame
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [3:0] BLANK_NIB = 4'(BLANK);

  // Active-low hex font; the blank code (when in range) overrides the glyph.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    if (BLANK <= 15 && int'(nib) == BLANK) return 7'h7F;
    case (nib)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  logic [SW-1:0]   pre;
  logic [TW-1:0]   scnt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   nidx;
  logic [4*ND-1:0] snap;
  logic [3:0]      nib;
  logic            scan_tick;
  logic            wrap;
  logic            step_term;

  always_comb begin
    scan_tick = (pre == SW'(SCAN_DIV - 1));
    wrap      = (idx == IW'(ND - 1));
    nidx      = wrap ? '0 : idx + IW'(1);
    // At a wrap edge the new snapshot is din itself, so decode straight from it.
    nib       = wrap ? din[4*nidx +: 4] : snap[4*nidx +: 4];
    step_term = (scnt == TW'(STEP_DIV - 1));
  end

  // Scan slot: prescaler, digit index, snapshot and display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre   <= '0;
      idx   <= IW'(ND - 1);
      snap  <= {ND{BLANK_NIB}};
      an    <= '1;
      seg   <= 7'h7F;
      frame <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (scan_tick) begin
        pre <= '0;
        idx <= nidx;
        an  <= ~(ND'(1) << nidx);
        seg <= decode(nib);
        if (wrap) begin
          snap  <= din;
          frame <= 1'b1;
        end
      end else begin
        pre <= pre + SW'(1);
      end
    end
  end

  // Step pacing: counter only advances while run is high, and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scnt <= '0;
      step <= 1'b0;
    end else begin
      step <= run && step_term;
      if (run) scnt <= step_term ? '0 : scnt + TW'(1);
    end
  end

endmodule
